packed_array_seq: RTL and testbench

- Sequencer and owner of a WA x WB packed 2D register array (element e occupies bits [e*WB +: WB]).
- Accepts element-range read/write requests over a valid/ready handshake.
- Processes a range one element per cycle, from index lo up to index hi.
- Returns the result over a second valid/ready handshake: a zero-extended read word, or a write acknowledge.
- Sits between bus-side masters and the packed-array datapath, so range, truncation and extension rules live in one place.

---
 rtl/packed_array_seq.sv | 176 +++++++++++++++++
 tb/tb_packed_array_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_array_seq.sv
// Range sequencer that owns a WA x WB packed register array and moves one element per cycle.
// Optional build macro PACKED_ARRAY_SIGN_EXT_EN: successful reads sign-extend from element hi.
module packed_array_seq #(
    parameter int WA = 8,
    parameter int WB = 8,
    parameter int IW = (WA > 1) ? $clog2(WA) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_wr,
    input  logic [IW-1:0]    req_lo,
    input  logic [IW-1:0]    req_hi,
    input  logic [WA*WB-1:0] req_dat,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_err,
    output logic [WA*WB-1:0] rsp_dat,
    output logic [WA*WB-1:0] arr
);

    localparam int W = WA * WB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One extra bit so that WA itself and a full-range count are representable.
    localparam logic [IW:0] WA_EXT = (IW + 1)'(WA);
    localparam logic [IW:0] ONE    = (IW + 1)'(1);

    logic [1:0]    state_q, state_d;
    logic          wr_q, wr_d;
    logic [IW-1:0] lo_q, lo_d;
    logic [IW-1:0] hi_q, hi_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic [IW:0]   n_q, n_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  arr_q, arr_d;
    logic [W-1:0]  rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    logic [IW:0]   lo_ext, hi_ext;
    logic          range_err;
    logic [IW:0]   cur_idx;
    logic          last;
    logic [WB-1:0] rd_elem;
    logic [WB-1:0] wr_elem;

    always_comb begin
        lo_ext    = {1'b0, req_lo};
        hi_ext    = {1'b0, req_hi};
        range_err = (lo_ext > hi_ext) || (hi_ext >= WA_EXT);
        cur_idx   = {1'b0, lo_q} + cnt_q;
        last      = (cnt_q == (n_q - ONE));
    end

    // Element currently addressed in the array, and the matching slice of the write data.
    always_comb begin
        rd_elem = '0;
        wr_elem = '0;
        for (int e = 0; e < WA; e++) begin
            if (int'(cur_idx) == e) begin
                rd_elem = arr_q[e*WB +: WB];
            end
            if (int'(cnt_q) == e) begin
                wr_elem = data_q[e*WB +: WB];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        data_d    = data_q;
        arr_d     = arr_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    wr_d      = req_wr;
                    lo_d      = req_lo;
                    hi_d      = req_hi;
                    data_d    = req_dat;
                    rsp_dat_d = '0;
                    cnt_d     = '0;
                    if (range_err) begin
                        rsp_err_d = 1'b1;
                        n_d       = '0;
                        state_d   = ST_RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        n_d       = hi_ext - lo_ext + ONE;
                        state_d   = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                for (int e = 0; e < WA; e++) begin
                    if (wr_q && (int'(cur_idx) == e)) begin
                        arr_d[e*WB +: WB] = wr_elem;
                    end
                    if (!wr_q && (int'(cnt_q) == e)) begin
                        rsp_dat_d[e*WB +: WB] = rd_elem;
                    end
                end
`ifdef PACKED_ARRAY_SIGN_EXT_EN
                // On the last read step rd_elem is element hi; replicate its MSB upward.
                if (!wr_q && last) begin
                    for (int e = 0; e < WA; e++) begin
                        if (e >= int'(n_q)) begin
                            rsp_dat_d[e*WB +: WB] = {WB{rd_elem[WB-1]}};
                        end
                    end
                end
`endif
                cnt_d = cnt_q + ONE;
                if (last) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_rdy) begin
                    rsp_err_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            data_q    <= '0;
            arr_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            data_q    <= data_d;
            arr_q     <= arr_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_rdy = (state_q == ST_IDLE);
    assign rsp_vld = (state_q == ST_RESP);
    assign rsp_err = rsp_err_q;
    assign rsp_dat = rsp_dat_q;
    assign arr     = arr_q;

endmodule

// File: tb/tb_packed_array_seq.sv
// Bench for packed_array_seq: directed and random range requests checked against an element-array model.
module tb_packed_array_seq;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int IW = 3;
    localparam int W  = WA * WB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [IW-1:0] req_lo;
    logic [IW-1:0] req_hi;
    logic [W-1:0]  req_dat;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic          rsp_err;
    logic [W-1:0]  rsp_dat;
    logic [W-1:0]  arr;

    packed_array_seq #(.WA(WA), .WB(WB)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_wr  (req_wr),
        .req_lo  (req_lo),
        .req_hi  (req_hi),
        .req_dat (req_dat),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_err (rsp_err),
        .rsp_dat (rsp_dat),
        .arr     (arr)
    );

    always #5 clk = ~clk;

    logic [WB-1:0] model [WA];
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    logic          exp_err;
    logic [W-1:0]  exp_dat;
    int            exp_lat;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_flat();
        logic [W-1:0] f = '0;
        for (int i = 0; i < WA; i++) f[i*WB +: WB] = model[i];
        return f;
    endfunction

    // Expected response and array effect of one request, straight from the range rules.
    task automatic predict(input bit wr, input int lo, input int hi, input logic [W-1:0] dat);
        int n;
        exp_err = (lo > hi) || (hi >= WA);
        exp_dat = '0;
        exp_lat = 0;
        if (!exp_err) begin
            n       = hi - lo + 1;
            exp_lat = n;
            for (int i = 0; i < n; i++) begin
                if (wr) model[lo+i] = dat[i*WB +: WB];
                else    exp_dat[i*WB +: WB] = model[lo+i];
            end
`ifdef PACKED_ARRAY_SIGN_EXT_EN
            if (!wr && model[hi][WB-1]) begin
                for (int i = n; i < WA; i++) exp_dat[i*WB +: WB] = '1;
            end
`endif
        end
    endtask

    // Present a request, let it be accepted, then scramble the request inputs.
    task automatic issue(input bit wr, input int lo, input int hi, input logic [W-1:0] dat);
        predict(wr, lo, hi, dat);
        req_vld = 1'b1;
        req_wr  = wr;
        req_lo  = lo[IW-1:0];
        req_hi  = hi[IW-1:0];
        req_dat = dat;
        check_bit("req_rdy_idle", req_rdy, 1'b1);
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        req_wr  = 1'($urandom);
        req_lo  = IW'($urandom);
        req_hi  = IW'($urandom);
        req_dat = {$urandom, $urandom};
    endtask

    task automatic wait_rsp(input string tag);
        int cyc = 0;
        while (rsp_vld !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, W'(cyc), W'(exp_lat));
        check_bit({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_dat"}, rsp_dat, exp_dat);
        check({tag, "_arr"}, arr, model_flat());
    endtask

    task automatic release_rsp(input string tag);
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        check_bit({tag, "_vld_clr"}, rsp_vld, 1'b0);
        check_bit({tag, "_rdy_back"}, req_rdy, 1'b1);
    endtask

    task automatic xact(input string tag, input bit wr, input int lo, input int hi,
                        input logic [W-1:0] dat);
        issue(wr, lo, hi, dat);
        wait_rsp(tag);
        release_rsp(tag);
    endtask

    initial begin
        logic [W-1:0] snap;
        logic [W-1:0] snap_arr;
        bit           wr;
        int           lo, hi, hold;

        rst     = 1'b1;
        req_vld = 1'b0;
        req_wr  = 1'b0;
        req_lo  = '0;
        req_hi  = '0;
        req_dat = '0;
        rsp_rdy = 1'b0;
        for (int i = 0; i < WA; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_arr", arr, '0);
        check_bit("reset_req_rdy", req_rdy, 1'b1);
        check_bit("reset_rsp_vld", rsp_vld, 1'b0);
        check_bit("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_dat", rsp_dat, '0);

        xact("rd_full_zero", 1'b0, 0, 7, '0);
        xact("wr_full", 1'b1, 0, 7, 64'h0123456789ABCDEF);
        check("wr_full_const", arr, 64'h0123456789ABCDEF);
        xact("rd_lo_gt_hi", 1'b0, 3, 2, '0);
        xact("wr_single", 1'b1, 5, 5, 64'hFFFF_FFFF_FFFF_FF5A);
        check("wr_single_const", arr, 64'h01235A6789ABCDEF);

        issue(1'b0, 2, 3, '0);
        wait_rsp("rd_2_3");
`ifdef PACKED_ARRAY_SIGN_EXT_EN
        check("rd_2_3_const", rsp_dat, 64'hFFFF_FFFF_FFFF_89AB);
`else
        check("rd_2_3_const", rsp_dat, 64'h0000_0000_0000_89AB);
`endif
        release_rsp("rd_2_3");

        // Backpressure: response held while a new request waits at the door.
        issue(1'b0, 0, 1, '0);
        wait_rsp("bp_rd");
        snap     = rsp_dat;
        snap_arr = arr;
        req_vld  = 1'b1;
        req_wr   = 1'b1;
        req_lo   = 3'd7;
        req_hi   = 3'd7;
        req_dat  = 64'h33;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_bit("bp_vld_hold", rsp_vld, 1'b1);
            check_bit("bp_rdy_low", req_rdy, 1'b0);
            check("bp_dat_hold", rsp_dat, snap);
            check("bp_arr_hold", arr, snap_arr);
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        check_bit("bp_idle_rdy", req_rdy, 1'b1);
        check_bit("bp_idle_vld", rsp_vld, 1'b0);
        predict(1'b1, 7, 7, 64'h33);
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        check_bit("bp_accepted", req_rdy, 1'b0);
        wait_rsp("bp_wr");
        release_rsp("bp_wr");

        for (int k = 0; k < 30; k++) begin
            wr = 1'($urandom);
            lo = int'($urandom_range(WA - 1, 0));
            hi = int'($urandom_range(WA - 1, 0));
            issue(wr, lo, hi, {$urandom, $urandom});
            wait_rsp("rand");
            hold = int'($urandom_range(2, 0));
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("rand_hold_dat", rsp_dat, exp_dat);
            end
            release_rsp("rand");
        end

        // Reset during the third busy cycle of a full write aborts it with no response.
        issue(1'b1, 0, 7, '1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < WA; i++) model[i] = '0;
        check("rst_mid_arr", arr, '0);
        check_bit("rst_mid_rdy", req_rdy, 1'b1);
        check_bit("rst_mid_vld", rsp_vld, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_bit("rst_mid_no_rsp", rsp_vld, 1'b0);
        xact("rd_after_rst", 1'b0, 0, 7, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
